// File: rtl/mdu_stall_if.sv
// E/D-stage multiply/divide and stall signals between the pipeline and the
// MDU scheduler. The master side is the pipeline; the slave side is the MDU.
interface mdu_stall_if;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_is_md;
    logic        hazard_stall_in;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_rd_data;
    logic        pc_en;
    logic        fd_en;
    logic        de_clr;

    modport master (
        output md_op, rs_val, rt_val, d_is_md, hazard_stall_in,
        input  start, busy, hi, lo, md_rd_data, pc_en, fd_en, de_clr
    );

    modport slave (
        input  md_op, rs_val, rt_val, d_is_md, hazard_stall_in,
        output start, busy, hi, lo, md_rd_data, pc_en, fd_en, de_clr
    );
endinterface

// File: rtl/mdu_stall_ctrl.sv
// Multiply/divide scheduler: owns HI/LO, sequences multi-cycle mult/div in E,
// and merges the MDU busy hazard with the data-hazard stall.
module mdu_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic         clk,
    input logic         reset,
    mdu_stall_if.slave  bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               is_start;
    logic               stall;
    logic [63:0]        result;

    // Full {HI,LO} result of the latched op; a zero divisor keeps HI/LO as they are.
    function automatic logic [63:0] mdu_result(input logic [3:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic [31:0] cur_hi,
                                               input logic [31:0] cur_lo);
        logic signed [63:0] sa64, sb64;
        logic        [63:0] ua64, ub64;
        logic signed [31:0] sa, sb, sq, sr;
        logic        [63:0] r;
        sa64 = $signed(a);
        sb64 = $signed(b);
        ua64 = {32'd0, a};
        ub64 = {32'd0, b};
        sa   = $signed(a);
        sb   = $signed(b);
        sq   = 32'sd0;
        sr   = 32'sd0;
        r    = {cur_hi, cur_lo};
        case (op)
            OP_MULT:  r = sa64 * sb64;
            OP_MULTU: r = ua64 * ub64;
            OP_DIV: begin
                if (b != 32'd0) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr, sq};
                end
            end
            OP_DIVU: begin
                if (b != 32'd0) r = {a % b, a / b};
            end
            default: r = {cur_hi, cur_lo};
        endcase
        return r;
    endfunction

    assign is_start = (bus.md_op == OP_MULT) || (bus.md_op == OP_MULTU) ||
                      (bus.md_op == OP_DIV)  || (bus.md_op == OP_DIVU);
    assign result   = mdu_result(op_q, a_q, b_q, hi_q, lo_q);

    // Next-state: accept a new op or HI/LO move only when idle, count down while busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (is_start) begin
                    op_d    = bus.md_op;
                    a_d     = bus.rs_val;
                    b_d     = bus.rt_val;
                    cnt_d   = (bus.md_op == OP_MULT || bus.md_op == OP_MULTU) ?
                              CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    state_d = BUSY;
                end else if (bus.md_op == OP_MTHI) begin
                    hi_d = bus.rs_val;
                end else if (bus.md_op == OP_MTLO) begin
                    lo_d = bus.rs_val;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = result[63:32];
                    lo_d    = result[31:0];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight and clears HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // An MDU op in D waits while E is starting or running an op; others only see the data hazard.
    always_comb begin
        stall = bus.hazard_stall_in | (bus.d_is_md & (is_start | (cnt_q != '0)));
    end

    assign bus.start      = is_start;
    assign bus.busy       = (cnt_q != '0);
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
    assign bus.md_rd_data = (bus.md_op == OP_MFHI) ? hi_q :
                            (bus.md_op == OP_MFLO) ? lo_q : 32'd0;
    assign bus.pc_en      = ~stall;
    assign bus.fd_en      = ~stall;
    assign bus.de_clr     = stall;
endmodule
